// File: rtl/serial_parity_pkg.sv
// Shared types for the bit-serial parity framer: FSM state encoding and length-width helper.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX; clear has priority over inc. Next value is
// formed one bit wider than the count so the saturate compare never sees a wrap.
module sat_counter #(
    parameter int MAX = 16,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_max
);

    localparam logic [W:0] MAX_EXT = (W+1)'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W:0]   value_inc;

    always_comb begin
        value_inc = {1'b0, value_q} + (W+1)'(1);
        value_d   = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && (value_inc <= MAX_EXT)) begin
            value_d = value_inc[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign at_max = ({1'b0, value_q} == MAX_EXT);

endmodule

// File: rtl/serial_parity_framer.sv
// Accumulates the XOR of a framed 1-bit stream; result registered one cycle after the last bit.
// Upstream stalls (up_ready=0) while a result waits in HOLD for down_ready.
module serial_parity_framer
    import serial_parity_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int LEN_W      = len_w(MAX_LEN),
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic             up_data,
    input  logic             up_last,
    output logic             up_ready,
    output logic             down_valid,
    output logic             down_parity,
    output logic [LEN_W-1:0] down_len,
    output logic             down_err,
    input  logic             down_ready
);

    localparam logic [LEN_W:0] MAX_EXT = (LEN_W+1)'(MAX_LEN);

    state_e           state_q, state_d;
    logic             acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             dv_q, dv_d;
    logic             dp_q, dp_d;
    logic [LEN_W-1:0] dl_q, dl_d;
    logic             de_q, de_d;

    logic [LEN_W-1:0] cnt;
    logic             cnt_at_max;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [LEN_W:0]   cnt_ext;
    logic             accept;

    sat_counter #(
        .MAX (MAX_LEN),
        .W   (LEN_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .inc    (cnt_inc),
        .value  (cnt),
        .at_max (cnt_at_max)
    );

    // Ready depends only on state (and reset), never on down_ready.
    assign up_ready = (state_q != HOLD) && !rst;
    assign accept   = up_valid && up_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        dv_d    = dv_q;
        dp_d    = dp_q;
        dl_d    = dl_q;
        de_d    = de_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        cnt_ext = {1'b0, cnt} + (LEN_W+1)'(1);

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (up_last) begin
                        dp_d    = acc_q ^ up_data ^ ODD_PARITY;
                        dl_d    = (cnt_ext > MAX_EXT) ? MAX_EXT[LEN_W-1:0] : cnt_ext[LEN_W-1:0];
                        de_d    = ovf_q | cnt_at_max;
                        dv_d    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        // Parity keeps covering bits past MAX_LEN; only the length saturates.
                        acc_d   = acc_q ^ up_data;
                        cnt_inc = 1'b1;
                        if (cnt_at_max) begin
                            ovf_d = 1'b1;
                        end
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (down_ready) begin
                    dv_d    = 1'b0;
                    acc_d   = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dv_q    <= 1'b0;
            dp_q    <= 1'b0;
            dl_q    <= '0;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            dv_q    <= dv_d;
            dp_q    <= dp_d;
            dl_q    <= dl_d;
            de_q    <= de_d;
        end
    end

    assign down_valid  = dv_q;
    assign down_parity = dp_q;
    assign down_len    = dl_q;
    assign down_err    = de_q;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench: three framer instances (even/16, odd/16, even/4) share one stimulus stream.
module tb_serial_parity_framer;

    logic clk = 1'b0;
    logic rst;
    logic up_valid, up_data, up_last, down_ready;

    logic       rdy0, rdy1, rdy2;
    logic       dv0, dv1, dv2;
    logic       dp0, dp1, dp2;
    logic [4:0] dl0, dl1;
    logic [2:0] dl2;
    logic       de0, de1, de2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_parity_framer #(.MAX_LEN(16), .ODD_PARITY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
        .up_ready(rdy0), .down_valid(dv0), .down_parity(dp0), .down_len(dl0),
        .down_err(de0), .down_ready(down_ready));

    serial_parity_framer #(.MAX_LEN(16), .ODD_PARITY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
        .up_ready(rdy1), .down_valid(dv1), .down_parity(dp1), .down_len(dl1),
        .down_err(de1), .down_ready(down_ready));

    serial_parity_framer #(.MAX_LEN(4), .ODD_PARITY(1'b0)) dut2 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
        .up_ready(rdy2), .down_valid(dv2), .down_parity(dp2), .down_len(dl2),
        .down_err(de2), .down_ready(down_ready));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted-or-offered beat; returns #1 after the edge.
    task automatic beat(input logic d, input logic l);
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        @(posedge clk); #1;
        up_valid = 1'b0;
        up_data  = 1'bx;
        up_last  = 1'bx;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = 1'b0;
        up_last    = 1'b0;
        down_ready = 1'b1;
        #2;
        check("rst_up_ready", rdy0, 1'b0);
        check("rst_down_valid", dv0, 1'b0);
        check("rst_down_len", dl0, 5'd0);
        check("rst_down_parity", dp0, 1'b0);
        check("rst_down_err", de0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("post_rst_up_ready", rdy0, 1'b1);
        tick();

        // Frame 1,0,1,1
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        check("f1_no_early_valid", dv0, 1'b0);
        beat(1'b1, 1'b1);
        check("f1_valid", dv0, 1'b1);
        check("f1_parity_even", dp0, 1'b1);
        check("f1_parity_odd", dp1, 1'b0);
        check("f1_len", dl0, 5'd4);
        check("f1_err", de0, 1'b0);
        check("f1_len_max4", dl2, 3'd4);
        check("f1_err_max4", de2, 1'b0);
        check("f1_up_ready_hold", rdy0, 1'b0);
        tick();
        check("f1_valid_drop", dv0, 1'b0);
        check("f1_up_ready_back", rdy0, 1'b1);

        // Single-bit frame
        beat(1'b1, 1'b1);
        check("f2_valid", dv1, 1'b1);
        check("f2_parity_odd", dp1, 1'b0);
        check("f2_parity_even", dp0, 1'b1);
        check("f2_len", dl1, 5'd1);
        check("f2_err", de1, 1'b0);
        tick();

        // Six ones: overflows MAX_LEN=4 instance
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check("f3_valid_max4", dv2, 1'b1);
        check("f3_parity_max4", dp2, 1'b0);
        check("f3_len_max4", dl2, 3'd4);
        check("f3_err_max4", de2, 1'b1);
        check("f3_len_max16", dl0, 5'd6);
        check("f3_err_max16", de0, 1'b0);
        tick();
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check("f4_parity_max4", dp2, 1'b0);
        check("f4_len_max4", dl2, 3'd2);
        check("f4_err_max4", de2, 1'b0);
        tick();

        // Backpressure with a 1-bit frame offered during the stall
        down_ready = 1'b0;
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        up_valid = 1'b1;
        up_data  = 1'b1;
        up_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", dv0, 1'b1);
            check("bp_parity", dp0, 1'b1);
            check("bp_len", dl0, 5'd3);
            check("bp_up_ready", rdy0, 1'b0);
            tick();
        end
        down_ready = 1'b1;
        tick();
        check("bp_release_valid", dv0, 1'b0);
        check("bp_release_up_ready", rdy0, 1'b1);
        tick();
        up_valid = 1'b0;
        up_data  = 1'bx;
        up_last  = 1'bx;
        check("bp_stalled_valid", dv0, 1'b1);
        check("bp_stalled_parity", dp0, 1'b1);
        check("bp_stalled_len", dl0, 5'd1);
        tick();

        // Gaps in up_valid with X data between beats
        beat(1'b1, 1'b0);
        tick();
        check("gap_no_valid", dv0, 1'b0);
        beat(1'b0, 1'b0);
        tick();
        beat(1'b1, 1'b1);
        check("gap_valid", dv0, 1'b1);
        check("gap_parity", dp0, 1'b0);
        check("gap_len", dl0, 5'd3);
        tick();

        // Async reset mid-frame
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_down_valid", dv0, 1'b0);
        check("arst_down_len", dl0, 5'd0);
        check("arst_up_ready", rdy0, 1'b0);
        tick(); tick();
        #2;
        rst = 1'b0;
        tick();
        check("arst_no_result", dv0, 1'b0);
        check("arst_up_ready_back", rdy0, 1'b1);
        beat(1'b1, 1'b1);
        check("arst_next_valid", dv0, 1'b1);
        check("arst_next_parity", dp0, 1'b1);
        check("arst_next_len", dl0, 5'd1);
        check("arst_next_err", de0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
